axi_lite_slave_mem: RTL
=======================

# axi_lite_slave_mem

AXI4-Lite slave word memory. It terminates the slave-side network adapter of the 4x4 NoC and is the endpoint that receives writes and reads issued by the master network adapters. It accepts AXI4-Lite write and read transactions, stores data in a register array with byte-strobe support, and returns OKAY responses for in-range addresses and SLVERR for out-of-range ones.

## Interface
Parameters:
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width. Only 32 is supported; STRB width is DATA_WIDTH/8.
- MEM_DEPTH, 16: number of 32-bit words. Must be a power of 2, at least 2.
- BASE_ADDR, 32'h70000000: window base. Must be aligned to MEM_DEPTH*4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awprot  in  3  accepted, ignored.
- s_axi_awvalid  in  1  / s_axi_awready  out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid  in  1  / s_axi_wready  out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  / s_axi_bready  in  1  write-response handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  accepted, ignored.
- s_axi_arvalid  in  1  / s_axi_arready  out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  / s_axi_rready  in  1  read-data handshake.

## Operation

**Address decode**
- Address is in range iff (addr & ~(MEM_DEPTH*4-1)) == BASE_ADDR.
- Word index = addr[2 +: log2(MEM_DEPTH)]. addr[1:0] is ignored.

**Write path**
- Two independent capture registers: AW (address and full flag) and W (data, strobe and full flag).
- awready = !aw_full && !bvalid. wready = !w_full && !bvalid.
- AW and W may arrive in either order or in the same cycle. Each is held until its partner arrives.
- When both are full and bvalid = 0, the write commits:
  - In range: each byte i with wstrb[i] = 1 is written; other bytes are unchanged. bresp = 2'b00.
  - Out of range: memory is unchanged. bresp = 2'b10.
  - Same edge: bvalid is set and both full flags are cleared.
- bvalid holds, with bresp stable, until bready = 1. It clears on that handshake edge.

**Read path**
- State machine R_IDLE -> R_RESP -> R_IDLE.
- R_IDLE: arready = 1. On arvalid, the handshake edge latches rdata and rresp and enters R_RESP.
  - In range: rdata = mem[index], rresp = 2'b00.
  - Out of range: rdata = 0, rresp = 2'b10.
- R_RESP: arready = 0, rvalid = 1. rdata and rresp are stable. On rready, return to R_IDLE and clear rvalid.

**Concurrency**
- The read and write paths run independently.
- If a write commit and a read latch hit the same word on the same edge, the read returns the pre-write value.

**Reset**
- Memory is cleared to 0. Both full flags are cleared. The read FSM goes to R_IDLE.
- Output values after reset: awready = 1, wready = 1, arready = 1, bvalid = 0, bresp = 0, rvalid = 0, rresp = 0, rdata = 0.
- Reset asserted mid-transaction abandons it: any pending B or R response is dropped, with no partial write.

## Timing
- Write, later of AW/W handshakes at edge n: memory update and bvalid = 1 at edge n+1.
  - Minimum write turnaround is 3 cycles with bready held high.
- Read, AR handshake at edge n: rvalid = 1 with data from edge n. With rready high, rvalid clears at edge n+1.
  - Back-to-back reads: one every 2 cycles.
- While bvalid = 1, no new AW or W is accepted. While rvalid = 1, no new AR is accepted.
- All outputs are registered or derived only from registers. There is no combinational path from a valid to a ready.

## Test plan
- Write 0x11000011, 0x22000022 and 0x33000033 to 0x70000000, 0x70000004 and 0x70000008 (wstrb = 4'hF), then read all three back -> each read returns the written value with rresp = 0; every bresp = 0.
- W presented 3 cycles before AW to 0x7000000C, data 0xDEADBEEF -> wready drops after the W handshake; bvalid rises one edge after the AW handshake; readback gives 0xDEADBEEF.
- Word at 0x70000000 holds 0x11000011; write 0xAABBCCDD with wstrb = 4'b0101 -> readback 0x11BB00DD.
- Write and read at 0x70000040 (out of range for MEM_DEPTH = 16) -> bresp = 2'b10 and no word changes; rresp = 2'b10 with rdata = 0.
- Hold bready low for 5 cycles after a write, and present a second AW/W -> bvalid stays high, awready = wready = 0, second write not accepted until one edge after the B handshake; hold rready low similarly -> rdata stable, arready = 0.
- Assert rst for 1 cycle while rvalid = 1 and an AW is pending -> next cycle rvalid = 0, bvalid = 0, all readies = 1; a read of 0x70000000 returns 0.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_mem
// AXI4-Lite slave word memory. It is the endpoint behind the slave-side network
// adapter. Writes support byte strobes. Addresses inside the window
// [BASE_ADDR, BASE_ADDR + MEM_DEPTH*4) return OKAY. All other addresses return
// SLVERR, and an out-of-window write leaves memory untouched.
//
// Ports
//   clk, rst                    single clock, synchronous active-high reset
//   s_axi_aw*                   write address channel (awprot ignored)
//   s_axi_w*                    write data channel with byte strobes
//   s_axi_b*                    write response channel
//   s_axi_ar*                   read address channel (arprot ignored)
//   s_axi_r*                    read data/response channel
// Every output is a flop.
// -----------------------------------------------------------------------------
module axi_lite_slave_mem #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h7000_0000)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned           STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~ADDR_WIDTH'(MEM_DEPTH * 4 - 1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Window hit: the address bits above the word-index field must equal the base.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & WIN_MASK) == BASE_ADDR;
    endfunction

    // Protection bits carry no meaning for this memory.
    logic unused_prot_c;
    assign unused_prot_c = ^{s_axi_awprot, s_axi_arprot};

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------------ write
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;

    logic                  aw_hs_c, w_hs_c, commit_c, wr_hit_c;
    logic [IDX_W-1:0]      wr_idx_c;

    assign aw_hs_c  = s_axi_awvalid && awready_q;
    assign w_hs_c   = s_axi_wvalid  && wready_q;
    // A commit fires only from registered captures, so no valid reaches a ready.
    assign commit_c = aw_full_q && w_full_q && !bvalid_q;
    assign wr_hit_c = in_window(aw_addr_q);
    assign wr_idx_c = aw_addr_q[2 +: IDX_W];

    // Write-path next state: capture AW/W independently, commit when both are held.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (aw_hs_c) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (w_hs_c) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (commit_c) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit_c ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d  && !bvalid_d;
    end

    // Write-path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // Storage array with per-byte write enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_c && wr_hit_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                    mem_q[wr_idx_c][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    rd_state_e             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  arready_q, arready_d;
    logic                  ar_hs_c;

    // arready is high only in R_IDLE, so a handshake implies the idle state.
    assign ar_hs_c = s_axi_arvalid && arready_q;

    // Read FSM next state. mem_q is sampled before any same-edge write lands.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    rd_state_d = R_RESP;
                    if (in_window(s_axi_araddr)) begin
                        rdata_d = mem_q[s_axi_araddr[2 +: IDX_W]];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase

        rvalid_d  = (rd_state_d == R_RESP);
        arready_d = (rd_state_d == R_IDLE);
    end

    // Read FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= arready_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule
